// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt entry sequencer: arbitrates RESET/NMI/IRQ/BRK, pushes PCH, PCL, P
// and fetches the vector. Ports: injector flags in, stack/PC/P in, bus and register-file strobes out.
module interrupt_sequencer #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enableFFs,
  input  logic        instructionBoundary,
  input  logic        resetDetected,
  input  logic        nmiGenerated,
  input  logic        irqGenerated,
  input  logic        brkDecoded,
  input  logic [7:0]  stackPointer,
  input  logic [15:0] programCounter,
  input  logic [7:0]  statusReg,
  output logic [15:0] address,
  output logic [7:0]  dataOut,
  output logic        writeEn,
  output logic        spDecrement,
  output logic        pcLoadLow,
  output logic        pcLoadHigh,
  output logic        setIFlag,
  output logic        interruptStarted,
  output logic        sequenceActive
);

  typedef enum logic [2:0] {
    IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI
  } state_t;

  typedef enum logic [2:0] {
    SRC_NONE, SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK
  } src_t;

  state_t      state;
  src_t        src;
  logic        we_q;
  logic        sp_dec_q;
  logic        started_q;
  logic        start;
  src_t        new_src;
  src_t        vec_src;
  logic [7:0]  push_p;
  logic [15:0] vec_addr;

  always_comb begin
    start = resetDetected |
            (instructionBoundary &
             (nmiGenerated | irqGenerated | brkDecoded));
    new_src = SRC_BRK;
    if (resetDetected)
      new_src = SRC_RST;
    else if (nmiGenerated)
      new_src = SRC_NMI;
    else if (irqGenerated)
      new_src = SRC_IRQ;
    // A late NMI steals the vector; the B bit is already on the stack.
    vec_src = src;
    if (nmiGenerated && (src == SRC_IRQ || src == SRC_BRK))
      vec_src = SRC_NMI;
    push_p = (statusReg & 8'hEF) | 8'h20 |
             ((src == SRC_BRK) ? 8'h10 : 8'h00);
    unique case (vec_src)
      SRC_RST: vec_addr = RST_VEC;
      SRC_NMI: vec_addr = NMI_VEC;
      default: vec_addr = IRQ_VEC;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      src            <= SRC_NONE;
      address        <= '0;
      dataOut        <= '0;
      we_q           <= 1'b0;
      sp_dec_q       <= 1'b0;
      pcLoadLow      <= 1'b0;
      pcLoadHigh     <= 1'b0;
      setIFlag       <= 1'b0;
      started_q      <= 1'b0;
      sequenceActive <= 1'b0;
    end else if (enableFFs) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state          <= PUSH_PCH;
            src            <= new_src;
            address        <= {STACK_PAGE, stackPointer};
            dataOut        <= programCounter[15:8];
            we_q           <= (new_src != SRC_RST);
            sp_dec_q       <= 1'b1;
            sequenceActive <= 1'b1;
          end
        end
        PUSH_PCH: begin
          // S drops at this same edge, so the next slot is S-1.
          state   <= PUSH_PCL;
          address <= {STACK_PAGE, stackPointer - 8'd1};
          dataOut <= programCounter[7:0];
        end
        PUSH_PCL: begin
          state   <= PUSH_P;
          address <= {STACK_PAGE, stackPointer - 8'd1};
          dataOut <= push_p;
        end
        PUSH_P: begin
          state     <= VEC_LO;
          src       <= vec_src;
          address   <= vec_addr;
          dataOut   <= '0;
          we_q      <= 1'b0;
          sp_dec_q  <= 1'b0;
          pcLoadLow <= 1'b1;
          setIFlag  <= 1'b1;
        end
        VEC_LO: begin
          state      <= VEC_HI;
          address    <= address + 16'd1;
          pcLoadLow  <= 1'b0;
          setIFlag   <= 1'b0;
          pcLoadHigh <= 1'b1;
          started_q  <= 1'b1;
        end
        VEC_HI: begin
          state          <= IDLE;
          src            <= SRC_NONE;
          address        <= '0;
          pcLoadHigh     <= 1'b0;
          started_q      <= 1'b0;
          sequenceActive <= 1'b0;
        end
        default: begin
          state <= IDLE;
          src   <= SRC_NONE;
        end
      endcase
    end
  end

  assign writeEn          = we_q & enableFFs;
  assign spDecrement      = sp_dec_q & enableFFs;
  assign interruptStarted = started_q & enableFFs;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: step-level reference model, directed scenarios
// with literal expectations, then randomized traffic with async reset pulses.
module tb_interrupt_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst = 1'b0;
  logic        enableFFs = 1'b0;
  logic        instructionBoundary = 1'b0;
  logic        resetDetected = 1'b0;
  logic        nmiGenerated = 1'b0;
  logic        irqGenerated = 1'b0;
  logic        brkDecoded = 1'b0;
  logic [7:0]  stackPointer = 8'hFD;
  logic [15:0] programCounter = 16'h0;
  logic [7:0]  statusReg = 8'h0;
  logic [15:0] address;
  logic [7:0]  dataOut;
  logic        writeEn;
  logic        spDecrement;
  logic        pcLoadLow;
  logic        pcLoadHigh;
  logic        setIFlag;
  logic        interruptStarted;
  logic        sequenceActive;

  interrupt_sequencer dut (
    .clk(clk),
    .nrst(nrst),
    .enableFFs(enableFFs),
    .instructionBoundary(instructionBoundary),
    .resetDetected(resetDetected),
    .nmiGenerated(nmiGenerated),
    .irqGenerated(irqGenerated),
    .brkDecoded(brkDecoded),
    .stackPointer(stackPointer),
    .programCounter(programCounter),
    .statusReg(statusReg),
    .address(address),
    .dataOut(dataOut),
    .writeEn(writeEn),
    .spDecrement(spDecrement),
    .pcLoadLow(pcLoadLow),
    .pcLoadHigh(pcLoadHigh),
    .setIFlag(setIFlag),
    .interruptStarted(interruptStarted),
    .sequenceActive(sequenceActive)
  );

  int checks = 0;
  int errors = 0;

  // model: step 0 idle, 1..5 = the five sequence cycles
  // src: 0 none, 1 reset, 2 nmi, 3 irq, 4 brk
  int          m_step = 0;
  int          m_src = 0;
  logic [7:0]  sp = 8'hFD;
  logic [15:0] t_pc = 16'h0;
  logic [7:0]  t_p = 8'h0;

  logic [23:0] wlog[$];
  logic [15:0] vlog[$];
  int          act_cnt = 0;

  function automatic logic [15:0] vec_of(int s);
    if (s == 1) return 16'hFFFC;
    if (s == 2) return 16'hFFFA;
    return 16'hFFFE;
  endfunction

  function automatic logic [30:0] expected();
    logic [15:0] a;
    logic [7:0]  d;
    logic we, sd, plo, phi, si, ist;
    a = 16'h0; d = 8'h0;
    we = 0; sd = 0; plo = 0; phi = 0; si = 0; ist = 0;
    if (m_step >= 1 && m_step <= 3) begin
      a  = {8'h01, sp};
      we = (m_src != 1) && enableFFs;
      sd = enableFFs;
      if (m_step == 1) d = t_pc[15:8];
      else if (m_step == 2) d = t_pc[7:0];
      else d = (t_p & 8'hEF) | 8'h20 | ((m_src == 4) ? 8'h10 : 8'h00);
    end else if (m_step == 4) begin
      a = vec_of(m_src); plo = 1; si = 1;
    end else if (m_step == 5) begin
      a = vec_of(m_src) + 16'd1; phi = 1; ist = enableFFs;
    end
    return {a, d, we, sd, plo, phi, si, ist, m_step != 0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] wl(int i);
    if (i < wlog.size()) return wlog[i];
    return 24'hFFFFFF;
  endfunction

  function automatic logic [15:0] vl(int i);
    if (i < vlog.size()) return vlog[i];
    return 16'h0000;
  endfunction

  task automatic cyc(input bit r, input bit e, input bit b,
                     input bit rd, input bit nm, input bit iq,
                     input bit bk);
    logic [30:0] got, exp;
    @(negedge clk);
    nrst = r; enableFFs = e; instructionBoundary = b;
    resetDetected = rd; nmiGenerated = nm;
    irqGenerated = iq; brkDecoded = bk;
    stackPointer = sp; programCounter = t_pc; statusReg = t_p;
    if (!r) begin m_step = 0; m_src = 0; end
    #1;
    got = {address, dataOut, writeEn, spDecrement, pcLoadLow,
           pcLoadHigh, setIFlag, interruptStarted, sequenceActive};
    exp = expected();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle t=%0t step=%0d got=%h exp=%h",
               $time, m_step, got, exp);
    end
    if (writeEn) wlog.push_back({address, dataOut});
    if (pcLoadLow && enableFFs) vlog.push_back(address);
    if (sequenceActive) act_cnt++;
    @(posedge clk);
    if (r && e) begin
      if (m_step >= 1 && m_step <= 3) sp = sp - 8'd1;
      if (m_step == 0) begin
        if (rd) begin m_src = 1; m_step = 1; end
        else if (b && (nm || iq || bk)) begin
          m_src = nm ? 2 : (iq ? 3 : 4);
          m_step = 1;
        end
      end else if (m_step == 3) begin
        if (nm && m_src >= 3) m_src = 2;
        m_step = 4;
      end else if (m_step == 5) begin
        m_step = 0; m_src = 0;
      end else begin
        m_step++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic clr();
    wlog.delete(); vlog.delete(); act_cnt = 0;
  endtask

  initial begin
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 1, 1);
    idle(2);

    // IRQ with textbook values
    t_pc = 16'h1234; t_p = 8'h00; sp = 8'hFD; clr();
    cyc(1, 1, 1, 0, 0, 1, 0);
    idle(7);
    chk("irq_nwr", wlog.size(), 3);
    chk("irq_w0", wl(0), 24'h01FD12);
    chk("irq_w1", wl(1), 24'h01FC34);
    chk("irq_w2", wl(2), 24'h01FB20);
    chk("irq_vec", vl(0), 16'hFFFE);
    chk("irq_sp", sp, 8'hFA);

    // BRK pushes B=1
    t_pc = 16'hC002; t_p = 8'h01; sp = 8'hF0; clr();
    cyc(1, 1, 1, 0, 0, 0, 1);
    idle(7);
    chk("brk_p", wl(2), 24'h01EE31);
    chk("brk_vec", vl(0), 16'hFFFE);

    // reset: no boundary needed, pushes become reads
    cyc(0, 1, 0, 0, 0, 0, 0);
    t_pc = 16'h5555; t_p = 8'h04; sp = 8'hFD; clr();
    cyc(1, 1, 0, 1, 0, 0, 0);
    idle(7);
    chk("rst_nwr", wlog.size(), 0);
    chk("rst_sp", sp, 8'hFA);
    chk("rst_vec", vl(0), 16'hFFFC);

    // NMI hijacks an IRQ during PUSH_P
    t_pc = 16'h8000; t_p = 8'h00; sp = 8'hFF; clr();
    cyc(1, 1, 1, 0, 0, 1, 0);
    idle(2);
    cyc(1, 1, 1, 0, 1, 0, 0);
    idle(6);
    chk("hij_p", wl(2), 24'h01FD20);
    chk("hij_vec", vl(0), 16'hFFFA);

    // NMI+IRQ together, IRQ held -> back-to-back sequences
    t_pc = 16'h0300; sp = 8'hFD; clr();
    cyc(1, 1, 1, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0, 1, 0);
    idle(8);
    chk("b2b_v0", vl(0), 16'hFFFA);
    chk("b2b_v1", vl(1), 16'hFFFE);
    chk("b2b_act", act_cnt, 10);

    // two-cycle stall in PUSH_PCL
    sp = 8'hFD; clr();
    cyc(1, 1, 1, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    idle(8);
    chk("stall_nwr", wlog.size(), 3);
    chk("stall_act", act_cnt, 7);

    // stack wrap through page boundary
    t_pc = 16'hABCD; t_p = 8'h80; sp = 8'h01; clr();
    cyc(1, 1, 1, 0, 0, 1, 0);
    idle(7);
    chk("wrap_w0", wl(0), 24'h0101AB);
    chk("wrap_w1", wl(1), 24'h0100CD);
    chk("wrap_w2", wl(2), 24'h01FFA0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (m_step == 0) begin
        t_pc = 16'($urandom);
        t_p  = 8'($urandom);
        if ($urandom % 4 == 0) sp = 8'($urandom % 3);
        else sp = 8'($urandom);
      end
      cyc(($urandom % 300) != 0, ($urandom % 5) != 0,
          ($urandom % 3) != 0, ($urandom % 60) == 0,
          ($urandom % 15) == 0, ($urandom % 6) == 0,
          ($urandom % 10) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
